// File: rtl/nv_nvdla_cfgrom_csb_bridge.sv
// CSB request/response front end for the combinational config ROM: one request in flight,
// registered read data, valid/ready response. Optional NVDLA_CFGROM_WR_ERR_EN flags writes as errors.
module nv_nvdla_cfgrom_csb_bridge #(
  parameter int ADDR_W = 22,
  parameter int OFS_W  = 12,
  parameter int CNT_W  = 8
) (
  input  logic                nvdla_core_clk,
  input  logic                nvdla_core_rst,
  input  logic                csb2cfgrom_req_pvld,
  output logic                csb2cfgrom_req_prdy,
  input  logic [ADDR_W+33:0]  csb2cfgrom_req_pd,
  output logic                cfgrom2csb_resp_valid,
  input  logic                cfgrom2csb_resp_ready,
  output logic [33:0]         cfgrom2csb_resp_pd,
  output logic [OFS_W-1:0]    reg_offset,
  output logic [31:0]         reg_wr_data,
  output logic                reg_wr_en,
  input  logic [31:0]         reg_rd_data,
  output logic [CNT_W-1:0]    cfgrom_illegal_wr_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_RESP} state_t;

`ifdef NVDLA_CFGROM_WR_ERR_EN
  localparam logic WR_ERR = 1'b1;
`else
  localparam logic WR_ERR = 1'b0;
`endif

  state_t           state_q, state_d;
  logic [OFS_W-1:0] ofs_q, ofs_d;
  logic [31:0]      wdat_q, wdat_d;
  logic             wr_q, wr_d;
  logic             np_q, np_d;
  logic [33:0]      pd_q, pd_d;

  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdat;
  logic              req_wr;
  logic              req_np;
  logic              unused_addr_hi;

  assign req_addr = csb2cfgrom_req_pd[ADDR_W-1:0];
  assign req_wdat = csb2cfgrom_req_pd[ADDR_W+31:ADDR_W];
  assign req_wr   = csb2cfgrom_req_pd[ADDR_W+32];
  assign req_np   = csb2cfgrom_req_pd[ADDR_W+33];
  // Upper word-address bits are decoded upstream and deliberately dropped here.
  assign unused_addr_hi = ^req_addr[ADDR_W-1:OFS_W-2];

  always_comb begin
    state_d = state_q;
    ofs_d   = ofs_q;
    wdat_d  = wdat_q;
    wr_d    = wr_q;
    np_d    = np_q;
    pd_d    = pd_q;
    unique case (state_q)
      S_IDLE: begin
        if (csb2cfgrom_req_pvld) begin
          ofs_d   = {req_addr[OFS_W-3:0], 2'b00};
          wdat_d  = req_wdat;
          wr_d    = req_wr;
          np_d    = req_np;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (!wr_q) begin
          pd_d    = {1'b0, 1'b0, reg_rd_data};
          state_d = S_RESP;
        end else if (np_q) begin
          pd_d    = {1'b1, WR_ERR, 32'h0};
          state_d = S_RESP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RESP: begin
        if (cfgrom2csb_resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      state_q <= S_IDLE;
      ofs_q   <= '0;
      wdat_q  <= '0;
      wr_q    <= 1'b0;
      np_q    <= 1'b0;
      pd_q    <= '0;
    end else begin
      state_q <= state_d;
      ofs_q   <= ofs_d;
      wdat_q  <= wdat_d;
      wr_q    <= wr_d;
      np_q    <= np_d;
      pd_q    <= pd_d;
    end
  end

  // Ready is masked during reset so nothing is accepted while the bridge is held.
  assign csb2cfgrom_req_prdy   = (state_q == S_IDLE) && !nvdla_core_rst;
  assign cfgrom2csb_resp_valid = (state_q == S_RESP);
  assign cfgrom2csb_resp_pd    = pd_q;
  assign reg_offset            = ofs_q;
  assign reg_wr_data           = wdat_q;
  assign reg_wr_en             = (state_q == S_LOOKUP) && wr_q;

`ifdef NVDLA_CFGROM_WR_ERR_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if ((state_q == S_LOOKUP) && wr_q && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) cnt_q <= '0;
    else                cnt_q <= cnt_d;
  end

  assign cfgrom_illegal_wr_cnt = cnt_q;
`else
  assign cfgrom_illegal_wr_cnt = '0;
`endif

endmodule

// File: tb/tb_nv_nvdla_cfgrom_csb_bridge.sv
// Directed scoreboard bench for nv_nvdla_cfgrom_csb_bridge; honours NVDLA_CFGROM_WR_ERR_EN.
module tb_nv_nvdla_cfgrom_csb_bridge;

`ifdef NVDLA_CFGROM_WR_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pvld = 1'b0;
  logic        prdy;
  logic [55:0] req_pd = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [33:0] resp_pd;
  logic [11:0] reg_offset;
  logic [31:0] reg_wr_data;
  logic        reg_wr_en;
  logic [31:0] reg_rd_data;
  logic [7:0]  wr_cnt;

  int checks = 0;
  int failures = 0;
  int exp_cnt = 0;
  logic [33:0] exp_q[$];

  always #5 clk = ~clk;

  // Combinational ROM stand-in: HW_VERSION at 0x000, 0x1 at 0x004, zero elsewhere.
  always_comb begin
    reg_rd_data = 32'h0;
    if (reg_offset == 12'h000) reg_rd_data = 32'h0001_0001;
    else if (reg_offset == 12'h004) reg_rd_data = 32'h0000_0001;
  end

  nv_nvdla_cfgrom_csb_bridge dut (
    .nvdla_core_clk        (clk),
    .nvdla_core_rst        (rst),
    .csb2cfgrom_req_pvld   (pvld),
    .csb2cfgrom_req_prdy   (prdy),
    .csb2cfgrom_req_pd     (req_pd),
    .cfgrom2csb_resp_valid (resp_valid),
    .cfgrom2csb_resp_ready (resp_ready),
    .cfgrom2csb_resp_pd    (resp_pd),
    .reg_offset            (reg_offset),
    .reg_wr_data           (reg_wr_data),
    .reg_wr_en             (reg_wr_en),
    .reg_rd_data           (reg_rd_data),
    .cfgrom_illegal_wr_cnt (wr_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One CSB transaction: drive at negedge, sample every following negedge.
  task automatic do_txn(input logic [21:0] addr, input logic [31:0] wdat, input logic wr,
                        input logic np, input int stall, input logic [31:0] exp_rdat);
    int n;
    logic [33:0] exp;
    n = 0;
    while (prdy !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_prdy_idle", {63'b0, prdy}, 64'd1);
    exp = wr ? {1'b1, ERR_EN, 32'h0} : {2'b00, exp_rdat};
    if (!wr || np) exp_q.push_back(exp);
    pvld   = 1'b1;
    req_pd = {np, wr, wdat, addr};
    @(negedge clk);
    pvld   = 1'b0;
    req_pd = {$urandom, $urandom};
    if (wr && exp_cnt < 255) exp_cnt++;
    chk("lookup_prdy", {63'b0, prdy}, 64'd0);
    chk("lookup_valid", {63'b0, resp_valid}, 64'd0);
    chk("reg_offset", {52'b0, reg_offset}, {52'b0, addr[9:0], 2'b00});
    chk("reg_wr_en", {63'b0, reg_wr_en}, {63'b0, wr});
    if (wr) chk("reg_wr_data", {32'b0, reg_wr_data}, {32'b0, wdat});
    @(negedge clk);
    chk("wr_en_pulse", {63'b0, reg_wr_en}, 64'd0);
    if (wr) chk("illegal_wr_cnt", {56'b0, wr_cnt}, 64'(ERR_EN ? exp_cnt : 0));
    if (!wr || np) begin
      chk("resp_valid_n2", {63'b0, resp_valid}, 64'd1);
      if (stall > 0) resp_ready = 1'b0;
      for (int i = 0; i < stall; i++) begin
        chk("stall_valid", {63'b0, resp_valid}, 64'd1);
        chk("stall_pd", {30'b0, resp_pd}, {30'b0, exp_q[0]});
        chk("stall_prdy", {63'b0, prdy}, 64'd0);
        @(negedge clk);
      end
      resp_ready = 1'b1;
      chk("resp_pd", {30'b0, resp_pd}, {30'b0, exp_q.pop_front()});
      @(negedge clk);
      chk("resp_valid_drop", {63'b0, resp_valid}, 64'd0);
      chk("prdy_after_resp", {63'b0, prdy}, 64'd1);
    end else begin
      chk("posted_no_resp", {63'b0, resp_valid}, 64'd0);
      chk("posted_prdy", {63'b0, prdy}, 64'd1);
    end
    $display("txn addr=%06h wr=%0d np=%0d wdat=%08h stall=%0d pd=%09h", addr, wr, np, wdat, stall, exp);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_prdy", {63'b0, prdy}, 64'd0);
    chk("rst_valid", {63'b0, resp_valid}, 64'd0);
    chk("rst_pd", {30'b0, resp_pd}, 64'd0);
    chk("rst_offset", {52'b0, reg_offset}, 64'd0);
    chk("rst_wr_data", {32'b0, reg_wr_data}, 64'd0);
    chk("rst_wr_en", {63'b0, reg_wr_en}, 64'd0);
    chk("rst_cnt", {56'b0, wr_cnt}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("prdy_after_rst", {63'b0, prdy}, 64'd1);

    // Reads: HW_VERSION, unmapped, word 1, word 1 with ignored upper address bits
    do_txn(22'h000000, 32'h0, 1'b0, 1'b1, 0, 32'h0001_0001);
    do_txn(22'h0003FF, 32'h0, 1'b0, 1'b1, 0, 32'h0);
    do_txn(22'h000001, 32'h0, 1'b0, 1'b0, 0, 32'h1);
    do_txn(22'h3FFC01, 32'h0, 1'b0, 1'b1, 0, 32'h1);
    // Backpressure, then an immediate follow-on request
    do_txn(22'h000000, 32'h0, 1'b0, 1'b1, 5, 32'h0001_0001);
    do_txn(22'h000001, 32'h0, 1'b0, 1'b1, 0, 32'h1);
    // Non-posted and posted writes
    do_txn(22'h000010, 32'h0000_DEAD, 1'b1, 1'b1, 0, 32'h0);
    do_txn(22'h000020, 32'hCAFE_F00D, 1'b1, 1'b0, 0, 32'h0);
    do_txn(22'h000002, 32'h1234_5678, 1'b1, 1'b1, 2, 32'h0);

    // Illegal-write counter saturation (stays zero without the macro)
    for (int k = 0; k < 300; k++) do_txn(22'(k), 32'(k), 1'b1, 1'b0, 0, 32'h0);
    chk("cnt_final", {56'b0, wr_cnt}, ERR_EN ? 64'd255 : 64'd0);

    // Reset while a response is stalled: it must be dropped
    @(negedge clk);
    pvld   = 1'b1;
    req_pd = {1'b1, 1'b0, 32'h0, 22'h000000};
    resp_ready = 1'b0;
    @(negedge clk);
    pvld = 1'b0;
    @(negedge clk);
    chk("t6_in_resp", {63'b0, resp_valid}, 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_valid_rst", {63'b0, resp_valid}, 64'd0);
    chk("t6_prdy_rst", {63'b0, prdy}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("t6_prdy_idle", {63'b0, prdy}, 64'd1);
    for (int i = 0; i < 4; i++) begin
      chk("t6_no_stale", {63'b0, resp_valid}, 64'd0);
      @(negedge clk);
    end
    resp_ready = 1'b1;
    $display("txn reset-drop read addr=000000");
    do_txn(22'h000001, 32'h0, 1'b0, 1'b1, 0, 32'h1);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
